// File: rtl/jtframe_sdram_rr_arb_pkg.sv
// Shared types and constants for the four-way SDRAM round-robin arbiter.
// The state enum, slot count and timeout-counter width live here so all files agree.
package jtframe_sdram_rr_arb_pkg;

  localparam int NREQ = 4;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic logic [NREQ-1:0] slot_mask(input logic [1:0] idx);
    slot_mask = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin winner selection.
// The search starts at last_i+1 and wraps, so the last winner has the lowest priority.
module jtframe_rr_pick
  import jtframe_sdram_rr_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic [1:0]      idx_o,
  output logic            valid_o
);

  logic [1:0] cand_s;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    idx_o   = 2'd0;
    valid_o = 1'b0;
    cand_s  = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = last_i + 2'(k);
      if (req_i[cand_s]) begin
        idx_o   = cand_s;
        valid_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_rr_arb.sv
// Four-slot round-robin arbiter in front of a single-port SDRAM controller.
// Strobes from the controller are steered combinationally to the granted slot.
module jtframe_sdram_rr_arb
  import jtframe_sdram_rr_arb_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int TOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_in,
  input  logic [NREQ*SDRAMW-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          req_dst,
  output logic [NREQ-1:0]          req_rdy,
  output logic                     sd_req,
  output logic [SDRAMW-1:0]        sd_addr,
  input  logic                     sd_ack,
  input  logic                     sd_dst,
  input  logic                     sd_rdy,
  output logic [1:0]               grant,
  output logic                     busy,
  output logic                     tout_err
);

  localparam logic [CNTW:0] TOUT_V = TOUT[CNTW:0];

  arb_state_e        state_q, state_d;
  logic              sd_req_q, sd_req_d;
  logic [SDRAMW-1:0] sd_addr_q, sd_addr_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              tout_q, tout_d;

  logic [1:0]        pick_idx_s;
  logic              pick_valid_s;
  logic [SDRAMW-1:0] sel_addr_s;
  logic [CNTW:0]     cnt_inc_s;
  logic              tout_hit_s;
  logic              done_s;
  logic              in_xfer_s;
  logic [NREQ-1:0]   gmask_s;

  jtframe_rr_pick u_pick (
    .req_i   (req_in),
    .last_i  (last_q),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign sel_addr_s = req_addr[int'(pick_idx_s)*SDRAMW +: SDRAMW];
  assign cnt_inc_s  = {1'b0, cnt_q} + {{CNTW{1'b0}}, 1'b1};
  assign tout_hit_s = (cnt_inc_s == TOUT_V);
  assign in_xfer_s  = (state_q == ST_REQ) || (state_q == ST_DATA);
  // Completion: rdy in DATA, or ack and rdy landing together while still in REQ.
  assign done_s     = sd_rdy && ((state_q == ST_DATA) || ((state_q == ST_REQ) && sd_ack));

  // Next-state logic for the arbitration FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    sd_req_d  = sd_req_q;
    sd_addr_d = sd_addr_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tout_d    = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d   = ST_REQ;
          grant_d   = pick_idx_s;
          sd_addr_d = sel_addr_s;
          sd_req_d  = 1'b1;
          cnt_d     = {CNTW{1'b0}};
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_REQ, ST_DATA: begin
        cnt_d = cnt_inc_s[CNTW-1:0];
        if (done_s) begin
          state_d  = ST_IDLE;
          sd_req_d = 1'b0;
          last_d   = grant_q;
        end else if (tout_hit_s) begin
          state_d  = ST_IDLE;
          sd_req_d = 1'b0;
          last_d   = grant_q;
          tout_d   = 1'b1;
        end else if ((state_q == ST_REQ) && sd_ack) begin
          state_d  = ST_DATA;
          sd_req_d = 1'b0;
        end else begin
          state_d  = state_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sd_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sd_req_q  <= 1'b0;
      sd_addr_q <= {SDRAMW{1'b0}};
      grant_q   <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= {CNTW{1'b0}};
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_req_q  <= sd_req_d;
      sd_addr_q <= sd_addr_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
    end
  end

  assign gmask_s  = slot_mask(grant_q);
  assign req_ack  = ((state_q == ST_REQ) && sd_ack) ? gmask_s : {NREQ{1'b0}};
  assign req_dst  = (in_xfer_s && sd_dst) ? gmask_s : {NREQ{1'b0}};
  assign req_rdy  = (in_xfer_s && sd_rdy) ? gmask_s : {NREQ{1'b0}};
  assign sd_req   = sd_req_q;
  assign sd_addr  = sd_addr_q;
  assign grant    = grant_q;
  assign busy     = in_xfer_s;
  assign tout_err = tout_q;

endmodule

// File: tb/tb_jtframe_sdram_rr_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of the round-robin arbiter.
module tb_jtframe_sdram_rr_arb;

  localparam int W  = 22;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req_in = 4'd0;
  logic [4*W-1:0] req_addr = '0;
  logic [3:0]     req_ack, req_dst, req_rdy;
  logic           sd_req;
  logic [W-1:0]   sd_addr;
  logic           sd_ack = 1'b0, sd_dst = 1'b0, sd_rdy = 1'b0;
  logic [1:0]     grant;
  logic           busy, tout_err;

  jtframe_sdram_rr_arb #(.SDRAMW(W), .TOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_addr(req_addr),
    .req_ack(req_ack), .req_dst(req_dst), .req_rdy(req_rdy),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_ack(sd_ack), .sd_dst(sd_dst),
    .sd_rdy(sd_rdy), .grant(grant), .busy(busy), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a transaction is either absent, awaiting ack, or awaiting data.
  int           m_phase;   // 0 none, 1 awaiting ack, 2 awaiting data
  int           m_last, m_grant, m_elapsed;
  logic [W-1:0] m_addr;
  logic         m_sdreq, m_tout;
  int           glog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] bit_of(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = 3; m_grant = 0; m_elapsed = 0;
    m_addr = '0; m_sdreq = 1'b0; m_tout = 1'b0;
  endtask

  task automatic check_outputs();
    logic [3:0] e_ack, e_dst, e_rdy;
    e_ack = (m_phase == 1 && sd_ack) ? bit_of(m_grant) : 4'd0;
    e_dst = (m_phase != 0 && sd_dst) ? bit_of(m_grant) : 4'd0;
    e_rdy = (m_phase != 0 && sd_rdy) ? bit_of(m_grant) : 4'd0;
    chk("sd_req",   64'(sd_req),   64'(m_sdreq));
    chk("sd_addr",  64'(sd_addr),  64'(m_addr));
    chk("grant",    64'(grant),    64'(m_grant));
    chk("busy",     64'(busy),     64'(m_phase != 0));
    chk("tout_err", 64'(tout_err), 64'(m_tout));
    chk("req_ack",  64'(req_ack),  64'(e_ack));
    chk("req_dst",  64'(req_dst),  64'(e_dst));
    chk("req_rdy",  64'(req_rdy),  64'(e_rdy));
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (req_in[c] && m_phase == 0) begin
          m_phase = 1; m_grant = c; m_addr = req_addr[c*W +: W];
          m_sdreq = 1'b1; m_elapsed = 0;
          glog.push_back(c);
        end
      end
    end else begin
      m_elapsed++;
      if (sd_rdy && (m_phase == 2 || sd_ack)) begin
        m_phase = 0; m_sdreq = 1'b0; m_last = m_grant;
      end else if (m_elapsed == TO) begin
        m_phase = 0; m_sdreq = 1'b0; m_last = m_grant; m_tout = 1'b1;
      end else if (m_phase == 1 && sd_ack) begin
        m_phase = 2; m_sdreq = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_strobes();
    sd_ack = 1'b0; sd_dst = 1'b0; sd_rdy = 1'b0;
  endtask

  initial begin
    logic pa;
    for (int i = 0; i < 4; i++) req_addr[i*W +: W] = W'($urandom);
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request with ack at cycle 3 and rdy at cycle 6.
    reset_pulse();
    req_addr[0 +: W] = 22'h12345;
    req_in = 4'b0001;
    cycle();
    req_in = 4'b0000;
    chk("t1_sdreq_c1", 64'(sd_req), 64'd1);
    cycle();
    cycle();
    sd_ack = 1'b1; #1;
    chk("t1_ack_c3", 64'(req_ack), 64'h1);
    chk("t1_addr", 64'(sd_addr), 64'h12345);
    cycle();
    sd_ack = 1'b0;
    chk("t1_sdreq_c4", 64'(sd_req), 64'd0);
    cycle();
    cycle();
    sd_rdy = 1'b1; #1;
    chk("t1_rdy_c6", 64'(req_rdy), 64'h1);
    chk("t1_grant", 64'(grant), 64'd0);
    cycle();
    sd_rdy = 1'b0;
    chk("t1_idle", 64'(busy), 64'd0);
    cycle();

    // All four requesting: eight transactions rotate 0,1,2,3,0,1,2,3.
    reset_pulse();
    glog.delete();
    req_in = 4'b1111;
    pa = 1'b0;
    for (int c = 0; c < 80 && glog.size() < 9; c++) begin
      sd_rdy = pa;
      sd_ack = sd_req;
      pa = sd_ack;
      cycle();
    end
    clear_strobes();
    req_in = 4'b0000;
    chk("rr_count_ok", 64'(glog.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_seq", 64'(glog[i]), 64'(i % 4));

    // Timeout with TOUT=20 and no ack.
    reset_pulse();
    req_in = 4'b0100;
    cycle();
    req_in = 4'b0000;
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) chk("to_not_yet", 64'(tout_err), 64'd0);
      cycle();
    end
    chk("to_err_c21", 64'(tout_err), 64'd1);
    chk("to_sdreq_c21", 64'(sd_req), 64'd0);
    req_in = 4'b1111;
    cycle();
    chk("to_next_grant", 64'(grant), 64'd3);
    req_in = 4'b0000;

    // Stray controller strobes while idle.
    reset_pulse();
    sd_ack = 1'b1; sd_rdy = 1'b1; sd_dst = 1'b1; #1;
    chk("stray_ack", 64'(req_ack), 64'd0);
    chk("stray_rdy", 64'(req_rdy), 64'd0);
    cycle();
    chk("stray_idle", 64'(busy), 64'd0);
    clear_strobes();
    cycle();

    // Reset while in DATA, then slot 3 alone.
    req_in = 4'b0001;
    cycle();
    req_in = 4'b0000;
    sd_ack = 1'b1;
    cycle();
    sd_ack = 1'b0;
    sd_dst = 1'b1; #1;
    chk("rst_dst_data", 64'(req_dst), 64'h1);
    reset_pulse();
    sd_dst = 1'b0;
    chk("rst_addr", 64'(sd_addr), 64'd0);
    req_in = 4'b1000;
    cycle();
    chk("rst_grant3", 64'(grant), 64'd3);
    req_in = 4'b0000;

    // Ack and rdy together while in REQ.
    reset_pulse();
    req_in = 4'b0110;
    cycle();
    sd_ack = 1'b1; sd_rdy = 1'b1; #1;
    chk("both_ack", 64'(req_ack), 64'h2);
    chk("both_rdy", 64'(req_rdy), 64'h2);
    cycle();
    clear_strobes();
    chk("both_idle", 64'(busy), 64'd0);
    cycle();
    chk("both_next", 64'(grant), 64'd2);
    req_in = 4'b0000;

    // Random traffic, including stray strobes, timeouts and occasional resets.
    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else begin
        req_in = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) req_addr[$urandom_range(0, 3)*W +: W] = W'($urandom);
        sd_ack = ($urandom_range(0, 4) == 0);
        sd_dst = ($urandom_range(0, 1) == 0);
        sd_rdy = ($urandom_range(0, 4) == 0);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_sdram_rr_arb.md
JTFRAME_SDRAM_RR_ARB -- requirements
Module: jtframe_sdram_rr_arb

Interface
REQ-001 SHALL have parameter SDRAMW, default 22, SDRAM word-address width.
REQ-002 SHALL have parameter TOUT, default 255, request timeout in cycles (1..255).
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_in, input, 4: level request per slot bank (0..3).
REQ-006 SHALL have port req_addr, input, 4*SDRAMW: packed address; slot n at bits [n*SDRAMW +: SDRAMW].
REQ-007 SHALL have port req_ack, output, 4: one-hot acknowledge to the granted requester.
REQ-008 SHALL have port req_dst, output, 4: one-hot data-start to the granted requester.
REQ-009 SHALL have port req_rdy, output, 4: one-hot data-ready to the granted requester.
REQ-010 SHALL have port sd_req, output, 1: request to SDRAM controller.
REQ-011 SHALL have port sd_addr, output, SDRAMW: address to SDRAM controller.
REQ-012 SHALL have ports sd_ack, sd_dst, sd_rdy, input, 1 each: controller ack, data start, data ready.
REQ-013 SHALL have port grant, output, 2: index of the current or last granted requester.
REQ-014 SHALL have port busy, output, 1: high in states REQ and DATA.
REQ-015 SHALL have port tout_err, output, 1: sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, REQ and DATA.
REQ-017 IDLE with any req_in bit set SHALL, in one cycle, pick the winner g, register grant=g and sd_addr=req_addr[g], set sd_req=1, and enter REQ; sd_req is therefore visible 1 cycle after req_in.
REQ-018 Winner selection SHALL be round-robin: search starts at last+1 mod 4, where last is the last completed grant; last resets to 3, so slot 0 wins first.
REQ-019 In REQ, sd_ack=1 SHALL clear sd_req on the next edge, move to DATA, and drive req_ack[g]=1 combinationally in that same cycle.
REQ-020 req_dst[g] and req_rdy[g] SHALL equal sd_dst and sd_rdy while in REQ or DATA, and be 0 otherwise; all other bits are 0.
REQ-021 sd_rdy in DATA SHALL set last=g and return to IDLE; a new grant needs at least one IDLE cycle.
REQ-022 sd_ack and sd_rdy asserted together in REQ SHALL route both strobes, set last=g, and return to IDLE.
REQ-023 sd_ack, sd_dst and sd_rdy received in IDLE SHALL be ignored and produce no req_* strobe.
REQ-024 A requester dropping req_in after the grant SHALL NOT abort the transaction.
REQ-025 An 8-bit cycle counter SHALL clear on entry to REQ and increment in REQ and DATA.
REQ-026 When the counter reaches TOUT, the block SHALL set tout_err=1, clear sd_req, set last=g, and return to IDLE; tout_err stays set until reset.
REQ-027 sd_addr and grant SHALL hold their values outside the IDLE-to-REQ transition.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, sd_req=0, sd_addr=0, grant=0, last=3, counter=0 and tout_err=0; req_ack, req_dst and req_rdy then read 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no further strobes; the first grant after reset follows REQ-018.

Structure
REQ-030 A shared package SHALL hold the state enumeration, NREQ=4, and the counter width of 8.
REQ-031 Winner selection SHALL live in the sub-module jtframe_rr_pick: 4-bit request and 2-bit last in, 2-bit index and valid out, purely combinational.

Verification
REQ-032 Single request: req_in=0001, addr0=0x12345, ack at cycle 3, rdy at cycle 6 -> sd_req high cycles 1..3, sd_addr=0x12345, req_ack=0001 at cycle 3, req_rdy=0001 at cycle 6, grant=0.
REQ-033 All four held at 1111 for 8 transactions -> grant sequence 0,1,2,3,0,1,2,3.
REQ-034 Timeout: TOUT=20, never assert sd_ack -> tout_err=1 and sd_req=0 at cycle 21; the next grant goes to slot last+1.
REQ-035 Stray strobes: pulse sd_rdy and sd_ack while in IDLE -> req_ack=0, req_rdy=0, state remains IDLE.
REQ-036 Reset during DATA: rst_n low for 1 cycle -> all outputs return to reset values; then req_in=1000 -> grant=3.
REQ-037 Same-cycle ack+rdy in REQ with req_in=0110 -> req_ack and req_rdy both 0010 in that cycle, IDLE next, the following grant goes to 2.
